// File: rtl/sb_chany_cfg_route.sv
// Configurable vertical switch-block routing stage.
// Per-track shift/tie-off muxes, optional pipeline flop, serial config chain.
module sb_chany_cfg_route #(
  parameter int W    = 9,
  parameter int NCFG = 6 * W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_start,
  input  logic         ccff_valid,
  input  logic         ccff_head,
  output logic         ccff_tail,
  output logic         cfg_done,
  input  logic [W-1:0] chany_bottom_in,
  input  logic [W-1:0] chany_top_in,
  output logic [W-1:0] chany_top_out,
  output logic [W-1:0] chany_bottom_out
);

  localparam int CW = $clog2(NCFG + 1);
  localparam logic [CW-1:0] LAST = CW'(NCFG - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [NCFG-1:0] cfg_q;
  logic            done_q;

  logic [2*W-1:0]  mux_v;
  logic [2*W-1:0]  reg_v;
  logic [2*W-1:0]  pipe_q;
  logic [2*W-1:0]  out_v;

  logic [W-1:0]    bot_n;
  logic [W-1:0]    bot_p;
  logic [W-1:0]    top_n;
  logic [W-1:0]    top_p;

  // n: track i sees i+1, p: track i sees i-1 (both wrap)
  assign bot_n = {chany_bottom_in[0], chany_bottom_in[W-1:1]};
  assign bot_p = {chany_bottom_in[W-2:0], chany_bottom_in[W-1]};
  assign top_n = {chany_top_in[0], chany_top_in[W-1:1]};
  assign top_p = {chany_top_in[W-2:0], chany_top_in[W-1]};

  function automatic logic pick(
    input logic [1:0] s,
    input logic       a,
    input logic       n,
    input logic       p
  );
    logic r;
    case (s)
      2'd0:    r = a;
      2'd1:    r = n;
      2'd2:    r = p;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < W; g++) begin : g_trk
    assign mux_v[g] = pick(
      cfg_q[3*g +: 2],
      chany_bottom_in[g], bot_n[g], bot_p[g]);
    assign mux_v[W+g] = pick(
      cfg_q[3*(W+g) +: 2],
      chany_top_in[g], top_n[g], top_p[g]);
    assign reg_v[g]   = cfg_q[3*g+2];
    assign reg_v[W+g] = cfg_q[3*(W+g)+2];
  end

  // Outputs isolated while the chain is being rewritten
  always_comb begin
    out_v = (reg_v & pipe_q) | (~reg_v & mux_v);
    if (state == SHIFT) begin
      out_v = '0;
    end
  end

  assign chany_top_out    = out_v[W-1:0];
  assign chany_bottom_out = out_v[2*W-1:W];
  assign ccff_tail        = cfg_q[NCFG-1];
  assign cfg_done         = done_q;

  // Pipeline flops capture the mux result every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= mux_v;
    end
  end

  // Chain-load FSM: counts accepted bits, restart wins over shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      cfg_q  <= '0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_start) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (cfg_start) begin
            cnt <= '0;
          end else if (ccff_valid) begin
            cfg_q <= {cfg_q[NCFG-2:0], ccff_head};
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (cfg_start) begin
            state  <= SHIFT;
            cnt    <= '0;
            done_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sb_chany_cfg_route.sv
// Bench for sb_chany_cfg_route.
// Random data against a bit-history reference model plus directed checks.
module tb_sb_chany_cfg_route;

  localparam int W    = 9;
  localparam int NCFG = 6 * W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_start = 1'b0;
  logic         ccff_valid = 1'b0;
  logic         ccff_head = 1'b0;
  logic         ccff_tail;
  logic         cfg_done;
  logic [W-1:0] chany_bottom_in = '0;
  logic [W-1:0] chany_top_in = '0;
  logic [W-1:0] chany_top_out;
  logic [W-1:0] chany_bottom_out;

  int vectors = 0;
  int miscompares = 0;

  sb_chany_cfg_route #(.W(W), .NCFG(NCFG)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_start        (cfg_start),
    .ccff_valid       (ccff_valid),
    .ccff_head        (ccff_head),
    .ccff_tail        (ccff_tail),
    .cfg_done         (cfg_done),
    .chany_bottom_in  (chany_bottom_in),
    .chany_top_in     (chany_top_in),
    .chany_top_out    (chany_top_out),
    .chany_bottom_out (chany_bottom_out)
  );

  always #5 clk = ~clk;

  // Model: hist holds last NCFG shifted bits, newest at the back.
  bit hist[$];
  bit m_loading;
  bit m_done;
  int m_cnt;
  bit m_pipe[2*W];

  function automatic bit m_bit(int p);
    return hist[NCFG-1-p];
  endfunction

  function automatic bit m_mux(int k);
    int i;
    int sel;
    logic [W-1:0] s;
    i   = k % W;
    s   = (k < W) ? chany_bottom_in : chany_top_in;
    sel = 2 * int'(m_bit(3*k+1)) + int'(m_bit(3*k));
    case (sel)
      0:       return s[i];
      1:       return s[(i+1) % W];
      2:       return s[(i+W-1) % W];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [W-1:0] m_out(bit top);
    logic [W-1:0] o;
    int k;
    o = '0;
    for (int i = 0; i < W; i++) begin
      k = top ? i : W + i;
      if (m_loading) o[i] = 1'b0;
      else if (m_bit(3*k+2)) o[i] = m_pipe[k];
      else o[i] = m_mux(k);
    end
    return o;
  endfunction

  task automatic m_reset();
    hist.delete();
    repeat (NCFG) hist.push_back(1'b0);
    m_loading = 1'b0;
    m_done = 1'b0;
    m_cnt = 0;
    for (int k = 0; k < 2*W; k++) m_pipe[k] = 1'b0;
  endtask

  task automatic m_edge();
    bit nxt[2*W];
    for (int k = 0; k < 2*W; k++) nxt[k] = m_mux(k);
    m_pipe = nxt;
    if (cfg_start) begin
      m_loading = 1'b1;
      m_done = 1'b0;
      m_cnt = 0;
    end else if (m_loading && ccff_valid) begin
      hist.push_back(ccff_head);
      hist.delete(0);
      m_cnt++;
      if (m_cnt == NCFG) begin
        m_loading = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("top_out", chany_top_out, m_out(1'b1));
    chk("bottom_out", chany_bottom_out, m_out(1'b0));
    chk("cfg_done", W'(cfg_done), W'(m_done));
    chk("ccff_tail", W'(ccff_tail), W'(hist[0]));
  endtask

  task automatic cycle_d(input logic st, input logic v, input logic h,
                         input logic [W-1:0] b, input logic [W-1:0] t);
    cfg_start = st;
    ccff_valid = v;
    ccff_head = h;
    chany_bottom_in = b;
    chany_top_in = t;
    @(negedge clk);
    check_all();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic cycle(input logic st, input logic v, input logic h);
    cycle_d(st, v, h, W'($urandom), W'($urandom));
  endtask

  task automatic load(input logic [NCFG-1:0] c, input int gap);
    cycle(1'b1, 1'($urandom), 1'b1);
    for (int j = NCFG - 1; j >= 0; j--) begin
      repeat ($urandom_range(0, gap)) cycle(1'b0, 1'b0, 1'($urandom));
      cycle(1'b0, 1'b1, c[j]);
    end
  endtask

  function automatic logic [NCFG-1:0] fill(logic [1:0] sel, logic r);
    logic [NCFG-1:0] c;
    c = '0;
    for (int k = 0; k < 2*W; k++) begin
      c[3*k +: 2] = sel;
      c[3*k+2] = r;
    end
    return c;
  endfunction

  logic [NCFG-1:0] alt;

  initial begin
    m_reset();

    // Reset pass-through
    chany_bottom_in = 9'h155;
    chany_top_in = 9'h0AA;
    repeat (2) @(negedge clk);
    chk("rst_top", chany_top_out, 9'h155);
    chk("rst_bot", chany_bottom_out, 9'h0AA);
    chk("rst_done", W'(cfg_done), '0);
    chk("rst_tail", W'(ccff_tail), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("idle_top", chany_top_out, 9'h155);
    chk("idle_bot", chany_bottom_out, 9'h0AA);
    repeat (6) cycle(1'b0, 1'($urandom), 1'($urandom));

    // Full load, shift-by-one
    load(fill(2'd1, 1'b0), 0);
    repeat (4) cycle(1'b0, 1'($urandom), 1'($urandom));
    cycle_d(1'b0, 1'b0, 1'b0, 9'h001, 9'h100);
    chk("sh1_top", chany_top_out, 9'h100);
    chk("sh1_bot", chany_bottom_out, 9'h080);
    chk("sh1_done", W'(cfg_done), W'(1));

    // Registered path, sel=2
    load(fill(2'd2, 1'b1), 2);
    cycle_d(1'b0, 1'b0, 1'b0, 9'h000, 9'h000);
    chany_bottom_in = 9'h001;
    #1 chk("reg_before", chany_top_out, 9'h000);
    cycle_d(1'b0, 1'b0, 1'b0, 9'h001, 9'h000);
    chk("reg_after", chany_top_out, 9'h002);
    repeat (6) cycle(1'b0, 1'($urandom), 1'($urandom));

    // Tie-off
    load(fill(2'd3, 1'($urandom)), 1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    cycle_d(1'b0, 1'b0, 1'b0, 9'h1FF, 9'h1FF);
    chk("tie_top", chany_top_out, 9'h000);
    chk("tie_bot", chany_bottom_out, 9'h000);

    // Daisy chain: alternating 1,0 starting with 1
    for (int j = 0; j < NCFG; j++) alt[j] = ((NCFG - 1 - j) % 2) == 0;
    load(alt, 1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < NCFG; n++) begin
      chk("daisy_tail", W'(ccff_tail), W'((n % 2) == 0));
      repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, 1'($urandom));
      cycle(1'b0, 1'b1, 1'($urandom));
    end
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Restart and stall
    cycle(1'b1, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 1'b1, 1'($urandom));
    cycle(1'b1, 1'b1, 1'b1);
    for (int n = 0; n < NCFG; n++) begin
      repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, 1'($urandom));
      if (n == NCFG - 1) chk("restart_early", W'(cfg_done), '0);
      cycle(1'b0, 1'b1, 1'($urandom));
    end
    chk("restart_done", W'(cfg_done), W'(1));
    repeat (6) cycle(1'b0, 1'($urandom), 1'($urandom));

    // Reset mid-load
    cycle(1'b1, 1'b0, 1'b0);
    repeat (30) cycle(1'b0, 1'b1, 1'($urandom));
    cfg_start = 1'b0;
    ccff_valid = 1'b0;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("mid_top", chany_top_out, chany_bottom_in);
    chk("mid_bot", chany_bottom_out, chany_top_in);
    chk("mid_done", W'(cfg_done), '0);
    chk("mid_tail", W'(ccff_tail), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) cycle(1'b0, 1'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sb_chany_cfg_route.md
# sb_chany_cfg_route

Configurable vertical routing stage that sits directly downstream of the pass-through Y connection block. It consumes the 9-track `chany_bottom_in`/`chany_top_in` buses and drives `chany_top_out`/`chany_bottom_out`. Each output track can be straight-through, shifted by one track, or tied off, and can be optionally registered. Per-track settings come from a serial configuration chain that is loaded by an internal shift FSM, with `ccff_head`/`ccff_tail` available for daisy-chaining to the next tile.

## Interface
- `W`, default 9: tracks per direction.
- `NCFG`, default 6*W (54): configuration chain length, 3 bits per output track.
- `clk`  in  1: single clock for the datapath and configuration logic.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cfg_start`  in  1: one-cycle pulse that begins a chain load.
- `ccff_valid`  in  1: qualifies `ccff_head` during a load.
- `ccff_head`  in  1: serial configuration bit in.
- `ccff_tail`  out  1: serial configuration bit out, equal to `cfg_q[NCFG-1]`.
- `cfg_done`  out  1: high when a complete load has finished and outputs are enabled.
- `chany_bottom_in`  in  W: tracks arriving from below.
- `chany_top_in`  in  W: tracks arriving from above.
- `chany_top_out`  out  W: tracks driven upward, sourced from `chany_bottom_in`.
- `chany_bottom_out`  out  W: tracks driven downward, sourced from `chany_top_in`.

## Operation
- **Configuration register `cfg_q[NCFG-1:0]`**
  - Shifts only in state SHIFT when `ccff_valid`=1: `cfg_q <= {cfg_q[NCFG-2:0], ccff_head}`.
- **Field map.** Output index k runs 0..W-1 for `chany_top_out[k]` and W..2W-1 for `chany_bottom_out[k-W]`.
  - `sel_k = cfg_q[3k+1:3k]`.
  - `reg_k = cfg_q[3k+2]`.
- **Source selection.** Let `src` be `chany_bottom_in` for top outputs and `chany_top_in` for bottom outputs, with i the track index and all index arithmetic mod W.
  - `sel`=0: `src[i]`.
  - `sel`=1: `src[i+1]`.
  - `sel`=2: `src[i-1]`, so i=0 takes `src[W-1]`.
  - `sel`=3: constant 0.
- **Optional register.** Each output has a pipeline flop `pipe_k` that captures the mux result every cycle.
  - `reg_k`=1: the output is `pipe_k`.
  - `reg_k`=0: the output is the mux result, combinationally.
- **FSM: IDLE, SHIFT, DONE.**
  - IDLE: after reset. `cfg_done`=0. `cfg_start` moves to SHIFT and clears `cnt`.
  - SHIFT: each `ccff_valid` cycle increments `cnt` (6-bit, range 0..NCFG). When the valid bit that makes `cnt`=NCFG is accepted, go to DONE. `cfg_start` while in SHIFT restarts: `cnt` is cleared and the state stays SHIFT. `cfg_q` is never cleared by a restart.
  - DONE: `cfg_done`=1. `cfg_start` moves back to SHIFT.
  - `ccff_valid` outside SHIFT is ignored and `cfg_q` holds.
- **Isolation.** While in SHIFT, both output buses are forced to 0. `pipe_k` keeps capturing.
- **IDLE outputs.** With reset config (all zeros), IDLE behaves as an exact pass-through, identical to unconfigured wiring.

## Timing
- **Reset values:** `cfg_q`=0, all `pipe_k`=0, state IDLE, `cnt`=0, `cfg_done`=0, `ccff_tail`=0. Both output buses read as `src` (combinational pass-through).
- **Latency**
  - `reg_k`=0: 0 cycles, combinational from input to output.
  - `reg_k`=1: 1 cycle.
- **Configuration timing**
  - A new `cfg_q` takes effect on the cycle after DONE is entered, when the outputs are un-gated.
  - `cfg_done` rises on the clock edge that accepts the NCFG-th valid bit.
  - `ccff_tail` changes only on shifting edges.
- **Simultaneous events**
  - `cfg_start` together with `ccff_valid` in SHIFT: the restart wins, `cnt`=0, and the bit is not shifted.
  - `cfg_start` in IDLE or DONE with `ccff_valid`=1: the bit is not shifted.
- **Reset mid-load:** `rst_n` low during SHIFT returns immediately to the reset state (IDLE, `cfg_q`=0). The partial load is discarded.
- **Gaps:** gaps in `ccff_valid` stall the count without penalty.

## Test plan
- **Reset pass-through.** Hold `rst_n`=0 then release, drive `chany_bottom_in`=9'h155 and `chany_top_in`=9'h0AA. Expect `chany_top_out`=9'h155 and `chany_bottom_out`=9'h0AA in the same cycle, `cfg_done`=0.
- **Full load, shift-by-one.** `cfg_start`, then 54 valid bits giving every sel=1 and reg=0. Outputs are 0 during the load and `cfg_done`=1 after the 54th bit. Then `chany_bottom_in`=9'h001 gives `chany_top_out`=9'h100, and `chany_top_in`=9'h100 gives `chany_bottom_out`=9'h080.
- **Registered path and sel=2.** Load sel=2 and reg=1 on all tracks. A `chany_bottom_in` step 9'h000→9'h001 gives `chany_top_out`=9'h002 exactly one cycle later. Tie-off: sel=3 gives 0 for any input.
- **Daisy chain.** After a load of an alternating 1,0 pattern, shift 54 further bits after a new `cfg_start`. `ccff_tail` reproduces the first-loaded sequence in order, starting with bit 1.
- **Restart and stall.** Shift 20 bits, pulse `cfg_start` together with `ccff_valid`, then shift 54 bits with random valid gaps. `cfg_done` asserts only after the 54th post-restart bit, and the bit presented with `cfg_start` is not absorbed.
- **Reset mid-load.** Assert `rst_n`=0 after 30 bits. Expect IDLE, `cfg_q`=0, pass-through restored, and `cfg_done`=0.
